pic_host_seq: RTL and testbench

PIC_HOST_SEQ -- requirements
Module: pic_host_seq

---
 rtl/pic_host_seq.sv | 153 +++++++++++++++
 tb/tb_pic_host_seq.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/pic_host_seq.sv
// rtl/pic_host_seq.sv - host-side sequencer: initialises an 8259-style PIC, runs INTA cycles and issues EOI writes
module pic_host_seq #(
  parameter int         SNGL       = 1,
  parameter int         IC4        = 1,
  parameter int         LTIM       = 1,
  parameter logic [7:0] ICW2_VAL   = 8'h70,
  parameter logic [7:0] ICW3_VAL   = 8'h00,
  parameter logic [7:0] ICW4_VAL   = 8'h02,
  parameter logic [7:0] MASK_VAL   = 8'h00,
  parameter int         WR_PULSE   = 2,
  parameter int         INTA_PULSE = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       intIn,
  input  logic [7:0] picDin,
  output logic [7:0] picDout,
  output logic       picCSn,
  output logic       picWRn,
  output logic       picRDn,
  output logic       picINTAn,
  output logic       picA0,
  input  logic       reinitReq,
  input  logic       eoiReq,
  input  logic       vecAck,
  output logic       initDone,
  output logic       vecValid,
  output logic [7:0] vecOut
);

  typedef enum logic [3:0] {
    INIT, W_SETUP, W_STROBE, W_HOLD, IDLE, ACK1, GAP, ACK2, VEC_WAIT
  } state_t;

  typedef enum logic [2:0] {
    W_ICW1, W_ICW2, W_ICW3, W_ICW4, W_OCW1, W_OCW2
  } word_t;

  localparam logic [7:0] ICW1_VAL = {3'b000, 1'b1, 1'(LTIM), 1'b0, 1'(SNGL), 1'(IC4)};
  localparam logic [7:0] OCW2_EOI = 8'h20;
  localparam logic [7:0] WR_LAST   = 8'(WR_PULSE - 1);
  localparam logic [7:0] INTA_LAST = 8'(INTA_PULSE - 1);

  state_t     state, state_n;
  word_t      cur_word, word_n;
  logic [7:0] cnt;
  logic       eoi_pend, reinit_pend;

  function automatic logic [7:0] word_data(input word_t w);
    case (w)
      W_ICW1:  return ICW1_VAL;
      W_ICW2:  return ICW2_VAL;
      W_ICW3:  return ICW3_VAL;
      W_ICW4:  return ICW4_VAL;
      W_OCW1:  return MASK_VAL;
      default: return OCW2_EOI;
    endcase
  endfunction

  // ICW1 and OCW2 go to A0=0, every other word to A0=1
  function automatic logic word_a0(input word_t w);
    return !(w == W_ICW1 || w == W_OCW2);
  endfunction

  // Skips ICW3 in single mode and ICW4 when IC4 is clear
  function automatic word_t word_after(input word_t w);
    case (w)
      W_ICW1:  return W_ICW2;
      W_ICW2:  return (SNGL == 0) ? W_ICW3 : ((IC4 != 0) ? W_ICW4 : W_OCW1);
      W_ICW3:  return (IC4 != 0) ? W_ICW4 : W_OCW1;
      default: return W_OCW1;
    endcase
  endfunction

  always_comb begin
    state_n = state;
    word_n  = cur_word;
    case (state)
      INIT: begin
        state_n = W_SETUP;
        word_n  = W_ICW1;
      end
      W_SETUP:  state_n = W_STROBE;
      W_STROBE: if (cnt == WR_LAST) state_n = W_HOLD;
      W_HOLD: begin
        if (cur_word == W_OCW1 || cur_word == W_OCW2) begin
          state_n = IDLE;
        end else begin
          state_n = W_SETUP;
          word_n  = word_after(cur_word);
        end
      end
      IDLE: begin
        if (reinitReq || reinit_pend) begin
          state_n = INIT;
        end else if (eoi_pend) begin
          state_n = W_SETUP;
          word_n  = W_OCW2;
        end else if (intIn) begin
          state_n = ACK1;
        end
      end
      ACK1:     if (cnt == INTA_LAST) state_n = GAP;
      GAP:      state_n = ACK2;
      ACK2:     if (cnt == INTA_LAST) state_n = VEC_WAIT;
      VEC_WAIT: if (vecAck) state_n = IDLE;
      default:  state_n = INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= INIT;
      cur_word    <= W_ICW1;
      cnt         <= '0;
      picDout     <= '0;
      picA0       <= 1'b0;
      vecOut      <= '0;
      initDone    <= 1'b0;
      eoi_pend    <= 1'b0;
      reinit_pend <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= (state_n == state) ? cnt + 8'd1 : 8'd0;

      // Data and address are registered once at setup and held through hold
      if (state_n == W_SETUP) begin
        cur_word <= word_n;
        picDout  <= word_data(word_n);
        picA0    <= word_a0(word_n);
      end

      if (state == ACK2 && state_n == VEC_WAIT) vecOut <= picDin;

      if (state_n == INIT) initDone <= 1'b0;
      else if (state == W_HOLD && state_n == IDLE && cur_word == W_OCW1) initDone <= 1'b1;

      if (state == IDLE && state_n == INIT) eoi_pend <= 1'b0;
      else if (eoiReq) eoi_pend <= 1'b1;
      else if (state == IDLE && state_n == W_SETUP) eoi_pend <= 1'b0;

      if (state == IDLE) reinit_pend <= 1'b0;
      else if (reinitReq) reinit_pend <= 1'b1;
    end
  end

  assign picCSn   = !(state == W_SETUP || state == W_STROBE || state == W_HOLD);
  assign picWRn   = (state != W_STROBE);
  assign picINTAn = !(state == ACK1 || state == ACK2);
  assign picRDn   = 1'b1;
  assign vecValid = (state == VEC_WAIT);

endmodule

// File: tb/tb_pic_host_seq.sv
// tb/tb_pic_host_seq.sv - directed bench for pic_host_seq: init, INTA cycle, EOI, reinit and reset abort
module tb_pic_host_seq;

  logic       clk = 1'b0;
  logic       rst1, rst2;
  logic       int_in, reinit_req, eoi_req, vec_ack;
  logic [7:0] pic_din;
  logic [7:0] zero_din;
  logic       low = 1'b0;
  logic       sel;

  logic [7:0] dout1, vout1, dout2, vout2;
  logic       cs1, wr1, rd1, inta1, a01, done1, vv1;
  logic       cs2, wr2, rd2, inta2, a02, done2, vv2;

  logic [7:0] m_dout;
  logic       m_cs, m_wr, m_a0, m_done;

  int checks = 0;
  int errors = 0;
  int overlap = 0;

  always #5 clk = ~clk;

  pic_host_seq dut (
    .clk(clk), .rst(rst1), .intIn(int_in), .picDin(pic_din), .picDout(dout1),
    .picCSn(cs1), .picWRn(wr1), .picRDn(rd1), .picINTAn(inta1), .picA0(a01),
    .reinitReq(reinit_req), .eoiReq(eoi_req), .vecAck(vec_ack),
    .initDone(done1), .vecValid(vv1), .vecOut(vout1)
  );

  pic_host_seq #(.SNGL(0), .ICW3_VAL(8'hFF)) dut2 (
    .clk(clk), .rst(rst2), .intIn(low), .picDin(zero_din), .picDout(dout2),
    .picCSn(cs2), .picWRn(wr2), .picRDn(rd2), .picINTAn(inta2), .picA0(a02),
    .reinitReq(low), .eoiReq(low), .vecAck(low),
    .initDone(done2), .vecValid(vv2), .vecOut(vout2)
  );

  assign m_dout = sel ? dout2 : dout1;
  assign m_cs   = sel ? cs2   : cs1;
  assign m_wr   = sel ? wr2   : wr1;
  assign m_a0   = sel ? a02   : a01;
  assign m_done = sel ? done2 : done1;

  always @(negedge clk) if (!wr1 && !inta1) overlap++;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Advances into a write's setup cycle and follows it through hold
  task automatic check_write(input string tag, input logic [7:0] d, input logic a0);
    step();
    chk({tag, " setup cs"}, 8'(m_cs), 8'd0);
    chk({tag, " setup wr"}, 8'(m_wr), 8'd1);
    chk({tag, " setup data"}, m_dout, d);
    chk({tag, " setup a0"}, 8'(m_a0), 8'(a0));
    step();
    chk({tag, " strobe1 wr"}, 8'(m_wr), 8'd0);
    step();
    chk({tag, " strobe2 wr"}, 8'(m_wr), 8'd0);
    chk({tag, " strobe2 data"}, m_dout, d);
    step();
    chk({tag, " hold wr"}, 8'(m_wr), 8'd1);
    chk({tag, " hold cs"}, 8'(m_cs), 8'd0);
    chk({tag, " hold data"}, m_dout, d);
    chk({tag, " hold a0"}, 8'(m_a0), 8'(a0));
  endtask

  initial begin
    rst1 = 1'b1; rst2 = 1'b1; int_in = 1'b0; reinit_req = 1'b0; eoi_req = 1'b0;
    vec_ack = 1'b0; pic_din = 8'h00; zero_din = 8'h00; sel = 1'b1;
    step(); step();
    chk("rst cs", 8'(cs1), 8'd1);
    chk("rst wr", 8'(wr1), 8'd1);
    chk("rst rd", 8'(rd1), 8'd1);
    chk("rst inta", 8'(inta1), 8'd1);
    chk("rst a0", 8'(a01), 8'd0);
    chk("rst dout", dout1, 8'h00);
    chk("rst done", 8'(done1), 8'd0);
    chk("rst vvalid", 8'(vv1), 8'd0);
    chk("rst vout", vout1, 8'h00);

    // Cascade configuration: five words including ICW3
    rst2 = 1'b0;
    check_write("c icw1", 8'h19, 1'b0);
    check_write("c icw2", 8'h70, 1'b1);
    check_write("c icw3", 8'hFF, 1'b1);
    check_write("c icw4", 8'h02, 1'b1);
    check_write("c ocw1", 8'h00, 1'b1);
    chk("c done before idle", 8'(done2), 8'd0);
    step();
    chk("c done", 8'(done2), 8'd1);
    chk("c idle cs", 8'(cs2), 8'd1);

    // Default configuration: four words, initDone on the 17th edge
    sel = 1'b0;
    rst1 = 1'b0;
    check_write("icw1", 8'h1B, 1'b0);
    check_write("icw2", 8'h70, 1'b1);
    check_write("icw4", 8'h02, 1'b1);
    check_write("ocw1", 8'h00, 1'b1);
    chk("done before idle", 8'(done1), 8'd0);
    step();
    chk("done", 8'(done1), 8'd1);
    chk("idle cs", 8'(cs1), 8'd1);

    // Interrupt acknowledge with EOI requests arriving during ACK1
    int_in = 1'b1; pic_din = 8'hAA;
    step();
    chk("ack1a inta", 8'(inta1), 8'd0);
    int_in = 1'b0; eoi_req = 1'b1;
    step();
    chk("ack1b inta", 8'(inta1), 8'd0);
    eoi_req = 1'b1;
    step();
    chk("gap inta", 8'(inta1), 8'd1);
    eoi_req = 1'b0; pic_din = 8'h74;
    step();
    chk("ack2a inta", 8'(inta1), 8'd0);
    step();
    chk("ack2b inta", 8'(inta1), 8'd0);
    chk("ack2b vvalid", 8'(vv1), 8'd0);
    step();
    chk("vwait vvalid", 8'(vv1), 8'd1);
    chk("vwait vout", vout1, 8'h74);
    chk("vwait inta", 8'(inta1), 8'd1);
    pic_din = 8'h00; eoi_req = 1'b1;
    step();
    eoi_req = 1'b0;
    step();
    chk("vhold vvalid", 8'(vv1), 8'd1);
    chk("vhold vout", vout1, 8'h74);
    chk("vhold cs", 8'(cs1), 8'd1);
    vec_ack = 1'b1;
    step();
    vec_ack = 1'b0;
    chk("acked vvalid", 8'(vv1), 8'd0);
    chk("acked cs", 8'(cs1), 8'd1);
    check_write("eoi", 8'h20, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("no second eoi cs", 8'(cs1), 8'd1);
    end
    chk("done after eoi", 8'(done1), 8'd1);

    // Reinit from IDLE, then reset during the second strobe of ICW2
    reinit_req = 1'b1;
    step();
    reinit_req = 1'b0;
    chk("reinit done", 8'(done1), 8'd0);
    chk("reinit cs", 8'(cs1), 8'd1);
    check_write("re icw1", 8'h1B, 1'b0);
    step();
    chk("re icw2 data", dout1, 8'h70);
    step();
    chk("re icw2 s1 wr", 8'(wr1), 8'd0);
    step();
    chk("re icw2 s2 wr", 8'(wr1), 8'd0);
    rst1 = 1'b1;
    step();
    rst1 = 1'b0;
    chk("abort cs", 8'(cs1), 8'd1);
    chk("abort wr", 8'(wr1), 8'd1);
    chk("abort inta", 8'(inta1), 8'd1);
    chk("abort dout", dout1, 8'h00);
    check_write("rs icw1", 8'h1B, 1'b0);
    check_write("rs icw2", 8'h70, 1'b1);

    chk("wr/inta overlap", 8'(overlap), 8'd0);
    chk("rd idle", 8'(rd1), 8'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
